// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 bus bundle shared by the memory-controller masters and BRAM slaves.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst,
    output adr, dat_ms, sel, we, stb, cyc, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  clk, rst,
    input  adr, dat_ms, sel, we, stb, cyc, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_bram_burst.sv
// Registered-feedback Wishbone BRAM slave: writes ack same cycle, reads ack 1 cycle later then 1 beat/clk in bursts.
// No internal backpressure; stb/cyc low or a write drops the burst and the next read re-pays 1 cycle.
module wb_bram_burst #(
  parameter int mem_adr_width = 11,
  parameter bit INIT_ZERO     = 1'b0
) (
  wshb_if.slave wb_s
);
  localparam int DEPTH = 2 ** mem_adr_width;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_q, state_d;
  logic                     ack_r, ack_r_d;
  logic                     req, rd_req, wr_req, is_burst;
  logic [mem_adr_width-1:0] cur_idx, nxt_idx, rd_idx, wrap_mask;
  logic [31:0]              rd_word;
  logic [31:0]              dat_q;
  logic                     unused_adr;

  assign req      = wb_s.cyc & wb_s.stb;
  assign rd_req   = req & ~wb_s.we;
  assign wr_req   = req & wb_s.we;
  assign is_burst = (wb_s.cti == 3'b010);
  assign cur_idx  = wb_s.adr[mem_adr_width+1:2];

  // Upper address bits alias; byte offset is implied by sel.
  assign unused_adr = ^{wb_s.adr[31:mem_adr_width+2], wb_s.adr[1:0]};

  always_comb begin
    wrap_mask = '1;
    case (wb_s.bte)
      2'b01:   wrap_mask = mem_adr_width'(4'h3);
      2'b10:   wrap_mask = mem_adr_width'(4'h7);
      2'b11:   wrap_mask = mem_adr_width'(4'hF);
      default: wrap_mask = '1;
    endcase
  end

  assign nxt_idx = (cur_idx & ~wrap_mask) | ((cur_idx + mem_adr_width'(1)) & wrap_mask);

  always_comb begin
    state_d = state_q;
    ack_r_d = 1'b0;
    rd_idx  = cur_idx;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (is_burst) begin
            ack_r_d = 1'b1;
            state_d = BURST;
          end else begin
            ack_r_d = ~ack_r;
          end
        end
      end
      BURST: begin
        // Master shows the beat being acked; prefetch the one after it.
        if (rd_req && is_burst) begin
          ack_r_d = 1'b1;
          rd_idx  = nxt_idx;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_s.clk) begin
    if (wb_s.rst) begin
      state_q <= IDLE;
      ack_r   <= 1'b0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      ack_r   <= ack_r_d;
      if (rd_req) begin
        dat_q <= rd_word;
      end
    end
  end

  generate
    if (INIT_ZERO) begin : g_mem_zero
      logic [31:0] mem [DEPTH] = '{default: 32'h0};
      always_ff @(posedge wb_s.clk) begin
        if (wr_req) begin
          for (int i = 0; i < 4; i++) begin
            if (wb_s.sel[i]) mem[cur_idx][8*i +: 8] <= wb_s.dat_ms[8*i +: 8];
          end
        end
      end
      assign rd_word = mem[rd_idx];
    end else begin : g_mem
      logic [31:0] mem [DEPTH];
      always_ff @(posedge wb_s.clk) begin
        if (wr_req) begin
          for (int i = 0; i < 4; i++) begin
            if (wb_s.sel[i]) mem[cur_idx][8*i +: 8] <= wb_s.dat_ms[8*i +: 8];
          end
        end
      end
      assign rd_word = mem[rd_idx];
    end
  endgenerate

  assign wb_s.dat_sm = dat_q;
  assign wb_s.ack    = wr_req | (ack_r & rd_req);
  assign wb_s.err    = 1'b0;
  assign wb_s.rty    = 1'b0;
endmodule

// File: tb/tb_wb_bram_burst.sv
// Bench for wb_bram_burst: classic vector table, burst sequences and reset/stall corner cases.
module tb_wb_bram_burst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wshb_if bus (.clk(clk), .rst(rst));
  wb_bram_burst #(.mem_adr_width(11), .INIT_ZERO(1'b0)) dut (.wb_s(bus));

  typedef struct {
    logic        c;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] model [2048];
  logic [31:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: read ack with no expected data (got %h)", nm, bus.dat_sm);
    end else begin
      e = exp_q.pop_front();
      check(nm, bus.dat_sm, e);
    end
  endtask

  task automatic sb_take(input string nm);
    if (bus.ack) sb_pop(nm);
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                       input logic [1:0] bt);
    @(posedge clk);
    #1;
    bus.cyc = c; bus.stb = s; bus.we = w; bus.adr = a;
    bus.dat_ms = d; bus.sel = sl; bus.cti = ct; bus.bte = bt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    for (int i = 0; i < 4; i++) if (sl[i]) model[a[12:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    drive(1'b1, 1'b1, 1'b1, a, d, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    check(nm, bus.ack, 1);
    model_write(a, d, 4'hF);
  endtask

  function automatic int nxt(input int idx, input logic [1:0] bt);
    int n;
    case (bt)
      2'b01:   n = 4;
      2'b10:   n = 8;
      2'b11:   n = 16;
      default: n = 2048;
    endcase
    return (idx - idx % n) + ((idx + 1) % n);
  endfunction

  task automatic burst(input int start, input logic [1:0] bt, input int len,
                       input int stall_at, input string nm);
    int idx, acks, n, first, last;
    bit issued, stalled, resume_chk;
    idx = start; acks = 0; n = 0; first = -1; last = -1;
    issued = 0; stalled = 0; resume_chk = 0;
    while (acks < len && n < 4 * len + 8) begin
      if (acks == stall_at && !stalled) begin
        drive(1'b1, 1'b0, 1'b0, 32'(idx) << 2, 32'h0, 4'h0, 3'b010, bt);
        @(negedge clk);
        check({nm, "_stall_ack"}, bus.ack, 0);
        stalled = 1;
        resume_chk = 1;
      end else begin
        drive(1'b1, 1'b1, 1'b0, 32'(idx) << 2, 32'h0, 4'h0,
              (acks == len - 1) ? 3'b111 : 3'b010, bt);
        if (!issued) begin
          exp_q.push_back(model[idx]);
          issued = 1;
        end
        @(negedge clk);
        if (resume_chk) begin
          check({nm, "_resume_lat"}, bus.ack, 0);
          resume_chk = 0;
        end
        if (bus.ack) begin
          sb_pop($sformatf("%s_beat%0d", nm, acks));
          if (first < 0) first = n;
          last = n;
          acks++;
          idx = nxt(idx, bt);
          issued = 0;
        end
      end
      n++;
    end
    if (issued && exp_q.size() > 0) void'(exp_q.pop_front());
    check({nm, "_beats"}, acks, len);
    check({nm, "_first_ack_cycle"}, first, 1);
    check({nm, "_span"}, last - first, len - 1 + (stalled ? 2 : 0));
    // Request still held as classic: no ack may leak out after the last beat.
    drive(1'b1, 1'b1, 1'b0, 32'(idx) << 2, 32'h0, 4'h0, 3'b000, bt);
    @(negedge clk);
    check({nm, "_end_ack"}, bus.ack, 0);
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0024, 32'h0123_4567, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'h0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h0123_4567};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFF_E010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0099, 4'h8, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h00BB_33DD};

    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = 0;
    bus.dat_ms = 0; bus.sel = 0; bus.cti = 0; bus.bte = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", bus.ack, 0);
    check("rst_dat", bus.dat_sm, 32'h0);
    check("rst_err", bus.err, 0);
    check("rst_rty", bus.rty, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].c, 1'b1, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 3'b000, 2'b00);
      if (!vecs[i].we) exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d_ack_first", i), bus.ack, vecs[i].c & vecs[i].we);
      if (vecs[i].we && vecs[i].c) model_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      if (!vecs[i].we) begin
        drive(vecs[i].c, 1'b1, 1'b0, vecs[i].adr, 32'h0, 4'h0, 3'b000, 2'b00);
        @(negedge clk);
        check($sformatf("vec%0d_ack_second", i), bus.ack, 1);
        sb_take($sformatf("vec%0d_dat", i));
      end
      idle();
    end

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 2'b00);
      @(negedge clk);
      check($sformatf("held_ack%0d", k), bus.ack, 32'(k % 2));
      if (k % 2 == 1) check($sformatf("held_dat%0d", k), bus.dat_sm, 32'hDEAD_BEEF);
    end
    idle();

    for (int w = 0; w < 8; w++) wr(32'(w) << 2, 32'(w), $sformatf("pre_ack%0d", w));
    wr(32'h1FFC, 32'h0000_07FF, "pre_ack_top");
    idle();

    burst(0,    2'b00, 8, -1, "lin8");
    burst(6,    2'b01, 4, -1, "wrap4");
    burst(5,    2'b10, 8, -1, "wrap8");
    burst(2047, 2'b00, 2, -1, "lin_top");
    burst(0,    2'b00, 8,  3, "stall");

    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b010, 2'b00);
    exp_q.push_back(model[0]);
    @(negedge clk);
    check("rstb_lat", bus.ack, 0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b010, 2'b00);
    @(negedge clk);
    check("rstb_ack0", bus.ack, 1);
    sb_take("rstb_dat0");
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 3'b010, 2'b00);
    rst = 1'b1;
    exp_q.push_back(model[1]);
    @(negedge clk);
    sb_take("rstb_dat1");
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b010, 2'b00);
    rst = 1'b0;
    exp_q.push_back(model[2]);
    @(negedge clk);
    check("rstb_next_ack", bus.ack, 0);
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b111, 2'b00);
    @(negedge clk);
    check("rstb_resume_ack", bus.ack, 1);
    sb_take("rstb_resume_dat");
    idle();

    drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h5A5A_5A5A, 4'hF, 3'b000, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ack", bus.ack, 1);
    drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_rd_lat", bus.ack, 0);
    drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 2'b00);
    @(negedge clk);
    check("rstw_rd_ack", bus.ack, 1);
    check("rstw_rd_dat", bus.dat_sm, 32'h5A5A_5A5A);
    idle();

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
